lcd_nibble_sequencer: RTL and testbench
=======================================

Name: lcd_nibble_sequencer

Overview:
- Downstream execution stage for the CPU's `LCD` instruction. Drives the Spartan-3E character LCD over its 4-bit bus (SF_D[11:8], LCD_E, LCD_RS, LCD_RW).
- Takes one byte, or one nibble for the power-on init sequence, from the CPU.
- Generates setup, enable-pulse and hold timing, the inter-nibble gap, and the post-command execution wait.
- Frees the instruction ROM program from 1 µs / 40 µs / 1.64 ms NOP padding around every character.

Parameters:
- P_SETUP, 2, cycles RS/data stable before E rises (40 ns at 50 MHz)
- P_PULSE, 12, cycles E held high (≥230 ns)
- P_HOLD, 1, cycles data held after E falls
- P_GAP, 50, cycles between high and low nibble; also the post-wait in nibble mode (1 µs)
- P_WAIT, 2000, post-byte execution wait (40 µs)
- P_LONG, 82000, post-wait for clear/home commands (1.64 ms)
- P_CW, 24, delay counter width

Ports:
- Clock  input  1  system clock, 50 MHz
- Reset  input  1  synchronous, active-high
- iStart  input  1  request; sampled only while oReady=1
- iData  input  8  byte to send; in nibble mode only iData[7:4] is used
- iRS  input  1  0 = command, 1 = character data
- iNibbleOnly  input  1  1 = send iData[7:4] only (init 0x3/0x2 writes)
- oReady  output  1  idle, can accept iStart
- oDone  output  1  one-cycle pulse when a transfer completes
- oLCD_Enabled  output  1  LCD_E
- oLCD_RegisterSelect  output  1  LCD_RS
- oLCD_ReadWrite  output  1  LCD_RW, constant 0
- oLCD_StrataFlashControl  output  1  constant 1; keeps StrataFlash off the shared bus
- oLCD_Data  output  4  SF_D[11:8]

Behaviour:
- Reset: state IDLE, counter 0, oReady=1, oDone=0, E=0, RS=0, data=0. Reset in any state aborts the transfer immediately. No oDone is issued for an aborted transfer.
- Accept: in IDLE with iStart=1, register iData, iRS, iNibbleOnly and the long flag. Long flag = (iRS=0 && iData<=8'h03 && !iNibbleOnly). From the next cycle oReady=0.
- iStart while busy: ignored, not queued. Later changes to iData, iRS and iNibbleOnly have no effect.
- FSM: IDLE -> SETUP_H(P_SETUP) -> PULSE_H(P_PULSE) -> HOLD_H(P_HOLD).
  - Nibble mode: HOLD_H -> WAIT with P_GAP.
  - Byte mode: HOLD_H -> GAP(P_GAP) -> SETUP_L(P_SETUP) -> PULSE_L(P_PULSE) -> HOLD_L(P_HOLD) -> WAIT, with P_LONG if the long flag is set, else P_WAIT.
  - WAIT -> IDLE.
- Each state lasts exactly its parameter count in cycles. One down-counter of width P_CW is loaded on state entry.
- E=1 only in PULSE_H and PULSE_L.
- oLCD_Data: high nibble in SETUP_H..HOLD_H; low nibble in SETUP_L..HOLD_L; 0 in IDLE, GAP and WAIT.
- RS = latched iRS from SETUP_H through HOLD_L; 0 otherwise.
- Completion: oDone=1 and oReady=1 in the first IDLE cycle after WAIT.
  - Byte, default params: 2080 busy cycles.
  - Byte with long flag: 82080 busy cycles.
  - Nibble mode: 65 busy cycles.
- iStart asserted in the same cycle as oDone is accepted (back-to-back).
- Parameter value 0 is illegal; flagged by an elaboration-time check.

Decomposition:
- Shared package/definitions include: state encodings (4-bit), default timing constants, and the long-command threshold 8'h03.
- One natural sub-module, lcd_delay_counter: loadable down-counter with a zero flag, reused for every timed state.

Test Plan:
- Reset, then iStart with iData=8'h48, iRS=1 -> E high for cycles 3–14 with data 0x4, then for cycles 68–79 with data 0x8; RS=1 throughout; oDone at cycle 2081.
- iData=8'h01, iRS=0 -> two E pulses with data 0x0 then 0x1; oDone after 82080 busy cycles.
- iNibbleOnly=1, iData=8'h30 -> single E pulse with data 0x3, RS=0; oDone after 65 cycles.
- iStart pulsed with iData=8'h6F mid-transfer of 8'h48 -> ignored; output nibbles remain 0x4/0x8.
- Reset asserted during PULSE_L -> next cycle E=0, data=0, oReady=1, and no oDone pulse.
- iStart held high continuously -> a new transfer begins in the oDone cycle; oReady low again the following cycle.

Source files
------------

// File: rtl/lcd_nibble_sequencer_pkg.sv
// Shared definitions for the character-LCD nibble sequencer:
// state encoding, default timing and the clear/home threshold.
package lcd_nibble_sequencer_pkg;

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_SETUP_H = 4'd1,
        S_PULSE_H = 4'd2,
        S_HOLD_H  = 4'd3,
        S_GAP     = 4'd4,
        S_SETUP_L = 4'd5,
        S_PULSE_L = 4'd6,
        S_HOLD_L  = 4'd7,
        S_WAIT    = 4'd8
    } state_t;

    localparam int D_SETUP = 2;
    localparam int D_PULSE = 12;
    localparam int D_HOLD  = 1;
    localparam int D_GAP   = 50;
    localparam int D_WAIT  = 2000;
    localparam int D_LONG  = 82000;
    localparam int D_CW    = 24;

    localparam logic [7:0] LONG_CMD_MAX = 8'h03;

    // Clear display (0x01) and return home (0x02/0x03) need the long wait.
    function automatic logic is_long(
        input logic [7:0] data,
        input logic       rs,
        input logic       nibble_only
    );
        return !rs && (data <= LONG_CMD_MAX) && !nibble_only;
    endfunction

endpackage

// File: rtl/lcd_nibble_sequencer_delay_counter.sv
// Loadable down-counter; zero marks the last cycle of a timed state.
module lcd_delay_counter #(
    parameter int P_CW = 24
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load,
    input  logic [P_CW-1:0] value,
    output logic            zero
);

    logic [P_CW-1:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= value;
        end else if (count != '0) begin
            count <= count - P_CW'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/lcd_nibble_sequencer.sv
// Spartan-3E character LCD write sequencer: 4-bit bus timing for
// one byte (two nibbles) or a single init nibble, plus execution wait.
module lcd_nibble_sequencer
    import lcd_nibble_sequencer_pkg::*;
#(
    parameter int P_SETUP = D_SETUP,
    parameter int P_PULSE = D_PULSE,
    parameter int P_HOLD  = D_HOLD,
    parameter int P_GAP   = D_GAP,
    parameter int P_WAIT  = D_WAIT,
    parameter int P_LONG  = D_LONG,
    parameter int P_CW    = D_CW
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       iStart,
    input  logic [7:0] iData,
    input  logic       iRS,
    input  logic       iNibbleOnly,
    output logic       oReady,
    output logic       oDone,
    output logic       oLCD_Enabled,
    output logic       oLCD_RegisterSelect,
    output logic       oLCD_ReadWrite,
    output logic       oLCD_StrataFlashControl,
    output logic [3:0] oLCD_Data
);

    if (P_SETUP < 1 || P_PULSE < 1 || P_HOLD < 1 || P_GAP < 1 ||
        P_WAIT < 1 || P_LONG < 1 || P_CW < 1) begin : g_zero_param
        $error("lcd_nibble_sequencer: timing parameters must be nonzero");
    end

    if ((longint'(P_LONG) - 1) >= (longint'(1) << P_CW)) begin : g_cw_param
        $error("lcd_nibble_sequencer: P_CW too narrow for P_LONG");
    end

    // Counter reaches zero on the last cycle, so load duration minus one.
    localparam logic [P_CW-1:0] L_SETUP = P_CW'(P_SETUP - 1);
    localparam logic [P_CW-1:0] L_PULSE = P_CW'(P_PULSE - 1);
    localparam logic [P_CW-1:0] L_HOLD  = P_CW'(P_HOLD - 1);
    localparam logic [P_CW-1:0] L_GAP   = P_CW'(P_GAP - 1);
    localparam logic [P_CW-1:0] L_WAIT  = P_CW'(P_WAIT - 1);
    localparam logic [P_CW-1:0] L_LONG  = P_CW'(P_LONG - 1);

    state_t          state;
    state_t          next_state;
    logic [7:0]      data_q;
    logic            rs_q;
    logic            nib_q;
    logic            long_q;
    logic            done_q;
    logic            done_next;
    logic            accept;
    logic            load;
    logic [P_CW-1:0] load_value;
    logic            zero;

    lcd_delay_counter #(
        .P_CW(P_CW)
    ) u_delay (
        .clk   (Clock),
        .reset (Reset),
        .load  (load),
        .value (load_value),
        .zero  (zero)
    );

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state  <= S_IDLE;
            done_q <= 1'b0;
            data_q <= '0;
            rs_q   <= 1'b0;
            nib_q  <= 1'b0;
            long_q <= 1'b0;
        end else begin
            state  <= next_state;
            done_q <= done_next;
            if (accept) begin
                data_q <= iData;
                rs_q   <= iRS;
                nib_q  <= iNibbleOnly;
                long_q <= is_long(iData, iRS, iNibbleOnly);
            end
        end
    end

    always_comb begin
        next_state = state;
        load       = 1'b0;
        load_value = '0;
        accept     = 1'b0;
        done_next  = 1'b0;
        unique case (state)
            S_IDLE: if (iStart) begin
                accept     = 1'b1;
                next_state = S_SETUP_H;
                load       = 1'b1;
                load_value = L_SETUP;
            end
            S_SETUP_H: if (zero) begin
                next_state = S_PULSE_H;
                load       = 1'b1;
                load_value = L_PULSE;
            end
            S_PULSE_H: if (zero) begin
                next_state = S_HOLD_H;
                load       = 1'b1;
                load_value = L_HOLD;
            end
            S_HOLD_H: if (zero) begin
                next_state = nib_q ? S_WAIT : S_GAP;
                load       = 1'b1;
                load_value = L_GAP;
            end
            S_GAP: if (zero) begin
                next_state = S_SETUP_L;
                load       = 1'b1;
                load_value = L_SETUP;
            end
            S_SETUP_L: if (zero) begin
                next_state = S_PULSE_L;
                load       = 1'b1;
                load_value = L_PULSE;
            end
            S_PULSE_L: if (zero) begin
                next_state = S_HOLD_L;
                load       = 1'b1;
                load_value = L_HOLD;
            end
            S_HOLD_L: if (zero) begin
                next_state = S_WAIT;
                load       = 1'b1;
                load_value = long_q ? L_LONG : L_WAIT;
            end
            S_WAIT: if (zero) begin
                next_state = S_IDLE;
                done_next  = 1'b1;
            end
            default: next_state = S_IDLE;
        endcase
    end

    always_comb begin
        oLCD_RegisterSelect = 1'b0;
        oLCD_Data           = 4'h0;
        unique case (state)
            S_SETUP_H, S_PULSE_H, S_HOLD_H: begin
                oLCD_RegisterSelect = rs_q;
                oLCD_Data           = data_q[7:4];
            end
            S_GAP: oLCD_RegisterSelect = rs_q;
            S_SETUP_L, S_PULSE_L, S_HOLD_L: begin
                oLCD_RegisterSelect = rs_q;
                oLCD_Data           = data_q[3:0];
            end
            default: oLCD_Data = 4'h0;
        endcase
    end

    assign oLCD_Enabled            = (state == S_PULSE_H) || (state == S_PULSE_L);
    assign oReady                  = (state == S_IDLE);
    assign oDone                   = done_q;
    assign oLCD_ReadWrite          = 1'b0;
    assign oLCD_StrataFlashControl = 1'b1;

endmodule

// File: tb/tb_lcd_nibble_sequencer.sv
// Bench for lcd_nibble_sequencer: cycle-offset reference model compared
// every cycle, plus directed transfers with literal timing expectations.
module tb_lcd_nibble_sequencer;

    localparam int SU = 2;
    localparam int PW = 12;
    localparam int HO = 1;
    localparam int GP = 50;
    localparam int WT = 2000;
    localparam int LG = 82000;

    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic       iStart = 1'b0;
    logic [7:0] iData = 8'h00;
    logic       iRS = 1'b0;
    logic       iNibbleOnly = 1'b0;
    logic       oReady;
    logic       oDone;
    logic       oLCD_Enabled;
    logic       oLCD_RegisterSelect;
    logic       oLCD_ReadWrite;
    logic       oLCD_StrataFlashControl;
    logic [3:0] oLCD_Data;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_on = 1'b0;

    lcd_nibble_sequencer dut (
        .Clock                   (Clock),
        .Reset                   (Reset),
        .iStart                  (iStart),
        .iData                   (iData),
        .iRS                     (iRS),
        .iNibbleOnly             (iNibbleOnly),
        .oReady                  (oReady),
        .oDone                   (oDone),
        .oLCD_Enabled            (oLCD_Enabled),
        .oLCD_RegisterSelect     (oLCD_RegisterSelect),
        .oLCD_ReadWrite          (oLCD_ReadWrite),
        .oLCD_StrataFlashControl (oLCD_StrataFlashControl),
        .oLCD_Data               (oLCD_Data)
    );

    initial forever #5 Clock = ~Clock;

    // Model: m_k counts busy cycles since acceptance (1 = first busy cycle).
    bit         m_busy = 1'b0;
    bit         m_done = 1'b0;
    int         m_k = 0;
    int         m_total = 0;
    logic [7:0] m_data = 8'h00;
    logic       m_rs = 1'b0;
    logic       m_nib = 1'b0;

    always @(posedge Clock) begin
        if (Reset) begin
            m_busy = 1'b0;
            m_done = 1'b0;
        end else if (!m_busy) begin
            m_done = 1'b0;
            if (iStart) begin
                m_busy  = 1'b1;
                m_k     = 1;
                m_data  = iData;
                m_rs    = iRS;
                m_nib   = iNibbleOnly;
                m_total = SU + PW + HO + (iNibbleOnly ? GP :
                          GP + SU + PW + HO +
                          ((!iRS && iData <= 8'h03) ? LG : WT));
            end
        end else if (m_k == m_total) begin
            m_busy = 1'b0;
            m_done = 1'b1;
        end else begin
            m_k++;
        end
    end

    function automatic logic [9:0] model_out();
        logic       e;
        logic       rs;
        logic [3:0] d;
        int         hi_end;
        int         lo_start;
        e = 1'b0;
        rs = 1'b0;
        d = 4'h0;
        hi_end = SU + PW + HO;
        lo_start = hi_end + GP + 1;
        if (m_busy) begin
            if (m_k <= hi_end) begin
                d  = m_data[7:4];
                rs = m_rs;
                e  = (m_k > SU) && (m_k <= SU + PW);
            end else if (!m_nib && m_k < lo_start) begin
                rs = m_rs;
            end else if (!m_nib && m_k < lo_start + hi_end) begin
                d  = m_data[3:0];
                rs = m_rs;
                e  = (m_k >= lo_start + SU) && (m_k < lo_start + SU + PW);
            end
        end
        return {!m_busy, m_done, e, rs, 1'b0, 1'b1, d};
    endfunction

    always @(negedge Clock) begin
        logic [9:0] exp_v;
        logic [9:0] act_v;
        if (chk_on) begin
            exp_v = model_out();
            act_v = {oReady, oDone, oLCD_Enabled, oLCD_RegisterSelect,
                     oLCD_ReadWrite, oLCD_StrataFlashControl, oLCD_Data};
            n_cmp++;
            if (act_v !== exp_v) begin
                n_bad++;
                $display("FAIL cycle_model t=%0t k=%0d rdy,done,e,rs,rw,sf,d got %b required %b",
                         $time, m_k, act_v, exp_v);
            end
        end
    end

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    int         r_done;
    int         r_cnt;
    int         r_rise[2];
    int         r_fall[2];
    logic [3:0] r_nib[2];

    // Start one transfer; optionally poke iStart at poke_k or reset at abort_k.
    task automatic xfer(input logic [7:0] d, input logic rs, input logic nib,
                        input int poke_k, input int abort_k);
        logic pe;
        bit   stop;
        pe = 1'b0;
        stop = 1'b0;
        r_done = -1;
        r_cnt = 0;
        r_rise = '{-1, -1};
        r_fall = '{-1, -1};
        r_nib = '{4'hx, 4'hx};
        @(negedge Clock);
        iStart = 1'b1;
        iData = d;
        iRS = rs;
        iNibbleOnly = nib;
        @(negedge Clock);
        iStart = 1'b0;
        iData = ~d;
        iRS = ~rs;
        iNibbleOnly = ~nib;
        for (int k = 1; k <= 90000 && !stop; k++) begin
            if (oLCD_Enabled && !pe && r_cnt < 2) begin
                r_rise[r_cnt] = k;
                r_nib[r_cnt] = oLCD_Data;
            end
            if (!oLCD_Enabled && pe && r_cnt < 2) begin
                r_fall[r_cnt] = k - 1;
                r_cnt++;
            end
            pe = oLCD_Enabled;
            if (oDone) begin
                r_done = k;
                stop = 1'b1;
            end else if (k == abort_k) begin
                Reset = 1'b1;
                @(negedge Clock);
                check("abort_e", oLCD_Enabled, 0);
                check("abort_data", oLCD_Data, 0);
                check("abort_ready", oReady, 1);
                check("abort_done", oDone, 0);
                Reset = 1'b0;
                stop = 1'b1;
            end else begin
                iStart = (k == poke_k);
                if (k == poke_k) iData = 8'h6F;
                @(negedge Clock);
            end
        end
        iStart = 1'b0;
        if (abort_k == 0 && r_done < 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL xfer_timeout: got no oDone, required one for data %h", d);
        end
    endtask

    initial begin
        int nd;
        int dk[2];
        int rdy_done;
        int rdy_after;
        int stray;

        repeat (2) @(negedge Clock);
        chk_on = 1'b1;
        check("rst_ready", oReady, 1);
        check("rst_done", oDone, 0);
        check("rst_e", oLCD_Enabled, 0);
        check("rst_rs", oLCD_RegisterSelect, 0);
        check("rst_data", oLCD_Data, 0);
        check("rst_rw", oLCD_ReadWrite, 0);
        check("rst_sf", oLCD_StrataFlashControl, 1);
        Reset = 1'b0;

        // 'H' as character data, with an ignored 0x6F request mid-transfer.
        xfer(8'h48, 1'b1, 1'b0, 30, 0);
        check("h_pulses", r_cnt, 2);
        check("h_rise0", r_rise[0], 3);
        check("h_fall0", r_fall[0], 14);
        check("h_nib0", r_nib[0], 4);
        check("h_rise1", r_rise[1], 68);
        check("h_fall1", r_fall[1], 79);
        check("h_nib1", r_nib[1], 8);
        check("h_done", r_done, 2081);

        // Clear display takes the long wait.
        xfer(8'h01, 1'b0, 1'b0, 0, 0);
        check("clr_pulses", r_cnt, 2);
        check("clr_rise0", r_rise[0], 3);
        check("clr_nib0", r_nib[0], 0);
        check("clr_rise1", r_rise[1], 68);
        check("clr_nib1", r_nib[1], 1);
        check("clr_done", r_done, 82081);

        // Init nibble 0x3.
        xfer(8'h30, 1'b0, 1'b1, 0, 0);
        check("nib_pulses", r_cnt, 1);
        check("nib_rise0", r_rise[0], 3);
        check("nib_fall0", r_fall[0], 14);
        check("nib_nib0", r_nib[0], 3);
        check("nib_done", r_done, 66);

        // Reset in the low-nibble pulse aborts with no completion.
        xfer(8'h48, 1'b1, 1'b0, 0, 70);
        stray = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge Clock);
            if (oDone) stray++;
        end
        check("abort_no_done", stray, 0);

        // iStart held high: each oDone cycle accepts the next request.
        @(negedge Clock);
        iStart = 1'b1;
        iData = 8'h20;
        iRS = 1'b0;
        iNibbleOnly = 1'b1;
        nd = 0;
        dk = '{-1, -1};
        rdy_done = -1;
        rdy_after = -1;
        for (int k = 1; k <= 400 && nd < 2; k++) begin
            @(negedge Clock);
            if (nd == 1 && k == dk[0] + 1) rdy_after = oReady;
            if (oDone) begin
                if (nd == 0) rdy_done = oReady;
                dk[nd] = k;
                nd++;
                if (nd == 2) iStart = 1'b0;
            end
        end
        iStart = 1'b0;
        check("b2b_count", nd, 2);
        check("b2b_done0", dk[0], 66);
        check("b2b_ready_at_done", rdy_done, 1);
        check("b2b_ready_after", rdy_after, 0);
        check("b2b_done1", dk[1], 132);
        repeat (4) @(negedge Clock);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
